udm_mem_responder: RTL and testbench
====================================

// Module: udm_mem_responder
// PURPOSE
//   Bus responder (target) for the udm debug bus; the counterpart of the udm bus initiator.
//   Accepts req/ack-handshaked read/write transactions and serves them from a local word-wide
//   RAM with byte enables.
//   Returns read data as a separate one-cycle resp pulse after a fixed, pipelined latency.
//   Used as an on-chip debug scratch memory and as the reference target in udm testbenches.
// PARAMETERS
//   ADDR_WIDTH   10             word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words
//   BASE_ADDR    32'h0000_0000  byte base address; aligned to 4*2**ADDR_WIDTH
//   ACK_DELAY    0              cycles req is held before ack (0 = ack in the same cycle as req)
//   RD_LATENCY   1              cycles from read acceptance to resp pulse; legal range >= 1
//   OOR_RDATA    32'hDEADBEEF   read data returned for out-of-range addresses
// PORTS
//   clk_i         in   1   clock
//   rst_i         in   1   reset; synchronous, active-high
//   bus_req_i     in   1   request valid; held with we/addr/be/wdata stable until ack
//   bus_ack_o     out  1   request accepted in this cycle when bus_req_i=1
//   bus_we_i      in   1   1 = write, 0 = read
//   bus_addr_bi   in   32  byte address; bits [1:0] ignored
//   bus_be_bi     in   4   byte enables; bit n enables wdata[8n+7:8n]; writes only
//   bus_wdata_bi  in   32  write data
//   bus_resp_o    out  1   one-cycle read-response strobe
//   bus_rdata_bo  out  32  read data; valid only while bus_resp_o=1, else 0
//   oor_cnt_bo    out  16  count of out-of-range accepted requests; saturates at 16'hFFFF
// BEHAVIOUR
// - Reset values: bus_resp_o=0, bus_rdata_bo=0, oor_cnt_bo=0.
//   Wait counter, response pipeline and in-flight reads are cleared.
//   RAM contents are not reset.
// - Accept: a transaction is accepted on a clock edge where bus_req_i & bus_ack_o.
//   At most one transaction is accepted per cycle.
// - Ack: bus_ack_o = bus_req_i & (wait_cnt == ACK_DELAY), combinational from wait_cnt.
//   wait_cnt increments each cycle with req=1 and no ack.
//   wait_cnt clears to 0 on acceptance or when req=0.
//   ACK_DELAY=0 gives ack in the same cycle as req, allowing back-to-back accepts every cycle.
// - Decode: in range iff addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
//   Word index = addr[ADDR_WIDTH+1:2].
// - Write, in range: on the acceptance edge, RAM[idx] byte n <= wdata byte n for each be[n]=1.
//   be=0000 is a legal no-op.
//   Writes produce no resp.
// - Read, in range: RAM[idx] is sampled at the acceptance edge.
//   A write accepted in an earlier cycle is visible; no same-cycle conflict is possible.
// - Out of range: writes are dropped, reads return OOR_RDATA.
//   Either case increments oor_cnt_bo (saturating).
//   The request is still acked normally.
// - Response pipeline: a shift register of RD_LATENCY stages carrying {valid, data}.
//   bus_resp_o rises exactly RD_LATENCY cycles after the acceptance edge.
//   Responses are returned in acceptance order.
//   There is no backpressure, so overflow is impossible (max one entry per stage).
//   Reads accepted on consecutive cycles give resp on consecutive cycles.
// - Writes between reads occupy no pipeline slot; response timing is unaffected.
// - Reset mid-operation: all in-flight reads are discarded and no resp pulse is emitted for them.
//   An ack is not issued in a cycle with rst_i=1.
//   Writes are not performed in a cycle with rst_i=1.
// - Protocol violation: req dropped before ack just clears wait_cnt; no transaction occurs.
// TESTING
// - T1 (ACK_DELAY=0, RD_LATENCY=1):
//   write addr=BASE+4, be=F, wdata=32'h12345678, then read BASE+4
//   -> ack in the same cycle as each req; single resp 1 cycle after read accept,
//      rdata=32'h12345678.
// - T2 byte enables: after T1, write BASE+4, be=4'b0101, wdata=32'hAABBCCDD, then read BASE+4
//   -> rdata=32'h12BB56DD.
// - T3 (RD_LATENCY=3): reads of BASE+0..+12 on 4 consecutive cycles (RAM preloaded with 1,2,3,4)
//   -> resp high for 4 consecutive cycles, starting 3 cycles after the first accept;
//      rdata 1,2,3,4 in order.
// - T4 (ACK_DELAY=2): req held from cycle 0
//   -> ack in cycle 2 only.
//   Req dropped in cycle 1 and re-raised in cycle 2
//   -> ack in cycle 4.
// - T5 out of range: write BASE+4*2**ADDR_WIDTH, then read the same address
//   -> RAM unchanged; resp rdata=32'hDEADBEEF; oor_cnt_bo=2.
// - T6 reset: read accepted, rst_i=1 on the next cycle for 1 cycle
//   -> no resp pulse for 8 cycles; oor_cnt_bo=0; RAM retains the T1 data.

Source files
------------

// File: rtl/udm_mem_responder.sv
// udm debug-bus target: req/ack transactions served from a byte-enabled word RAM,
// read data returned as a one-cycle resp strobe after a fixed pipelined latency.
module udm_mem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ACK_DELAY  = 0,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] OOR_RDATA  = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    output logic        bus_ack_o,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic [15:0] oor_cnt_bo
);

    localparam int WAIT_W = (ACK_DELAY < 2) ? 1 : $clog2(ACK_DELAY + 1);
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    logic [WAIT_W-1:0]     wait_cnt;
    logic                  accept;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word;
    logic [31:0]           mem [DEPTH];
    logic                  pipe_valid [RD_LATENCY];
    logic [31:0]           pipe_data [RD_LATENCY];
    logic [15:0]           oor_cnt;
    logic                  unused_addr_lsbs;

    // Handshake: the initiator holds req and its payload stable until ack; a transaction
    // is accepted on the edge where req & ack, and ack never rises while reset is asserted.
    assign bus_ack_o = bus_req_i & ~rst_i & (wait_cnt == WAIT_W'(ACK_DELAY));
    assign accept    = bus_ack_o;

    assign in_range         = (bus_addr_bi[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign word_idx         = bus_addr_bi[ADDR_WIDTH+1:2];
    assign rd_word          = in_range ? mem[word_idx] : OOR_RDATA;
    assign unused_addr_lsbs = ^bus_addr_bi[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i || !bus_req_i || bus_ack_o) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // RAM contents deliberately have no reset.
    always_ff @(posedge clk_i) begin
        if (accept && bus_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_be_bi[b]) begin
                    mem[word_idx][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= accept & ~bus_we_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Data stages need no reset: the output is masked by the valid bit.
    always_ff @(posedge clk_i) begin
        pipe_data[0] <= rd_word;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oor_cnt <= '0;
        end else if (accept && !in_range && (oor_cnt != 16'hFFFF)) begin
            oor_cnt <= oor_cnt + 16'd1;
        end
    end

    // Gating with rst_i keeps a read that is already at the last stage from pulsing during reset.
    assign bus_resp_o   = pipe_valid[RD_LATENCY-1] & ~rst_i;
    assign bus_rdata_bo = bus_resp_o ? pipe_data[RD_LATENCY-1] : 32'h0;
    assign oor_cnt_bo   = oor_cnt;

endmodule

// File: tb/tb_udm_mem_responder.sv
// Bench for udm_mem_responder: three instances with different ack/latency settings,
// a word-array reference model and a per-instance expected-response queue.
module tb_udm_mem_responder;

    localparam int          NDUT  = 3;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam logic [31:0] OOR_D = 32'hDEADBEEF;

    logic            clk = 1'b0;
    logic            rst;
    logic [NDUT-1:0] req, we, ack, resp;
    logic [31:0]     addr [NDUT];
    logic [31:0]     wdata [NDUT];
    logic [31:0]     rdata [NDUT];
    logic [3:0]      be [NDUT];
    logic [15:0]     oor [NDUT];

    int cyc = 0;
    int compared = 0;
    int errors = 0;

    logic [31:0] mmem [NDUT][DEPTH];
    int          oor_m [NDUT];
    logic [31:0] exp_q [NDUT][$];
    int          due_q [NDUT][$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        udm_mem_responder #(
            .ADDR_WIDTH(AW),
            .BASE_ADDR (BASE),
            .ACK_DELAY (g == 2 ? 2 : 0),
            .RD_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 2)),
            .OOR_RDATA (OOR_D)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .bus_req_i   (req[g]),
            .bus_ack_o   (ack[g]),
            .bus_we_i    (we[g]),
            .bus_addr_bi (addr[g]),
            .bus_be_bi   (be[g]),
            .bus_wdata_bi(wdata[g]),
            .bus_resp_o  (resp[g]),
            .bus_rdata_bo(rdata[g]),
            .oor_cnt_bo  (oor[g])
        );
    end

    // clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ack_dly(input int d);
        return (d == 2) ? 2 : 0;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flush_all();
        for (int d = 0; d < NDUT; d++) begin
            exp_q[d].delete();
            due_q[d].delete();
            oor_m[d] = 0;
        end
    endtask

    // driver: called at a negedge; returns at the negedge after acceptance with req still high
    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
        int waited;
        bit got;
        int i;
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        waited = 0;
        got = 0;
        while (!got && waited <= 20) begin
            #1;
            if (ack[d]) got = 1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        compared++;
        if (!got || waited != ack_dly(d)) begin
            errors++;
            $display("FAIL ack_wait dut%0d: waited %0d cycles (acked=%0d), required %0d",
                     d, waited, got, ack_dly(d));
        end
        if (!got) begin
            req[d] = 1'b0;
            @(negedge clk);
            return;
        end
        if (in_rng(a)) begin
            i = int'((a - BASE) >> 2);
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mmem[d][i][8*k +: 8] = wd[8*k +: 8];
            end else begin
                exp_q[d].push_back(mmem[d][i]);
                due_q[d].push_back(cyc + lat(d));
            end
        end else begin
            if (oor_m[d] < 16'hFFFF) oor_m[d]++;
            if (!w) begin
                exp_q[d].push_back(OOR_D);
                due_q[d].push_back(cyc + lat(d));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int d, input int n);
        req[d] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // scoreboard monitor
    initial begin
        logic [31:0] e;
        int du;
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < NDUT; d++) begin
                if (resp[d]) begin
                    compared++;
                    if (exp_q[d].size() == 0) begin
                        errors++;
                        $display("FAIL resp_unexpected dut%0d: got resp data %h, required no resp",
                                 d, rdata[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        du = due_q[d].pop_front();
                        if (rdata[d] !== e || du != cyc) begin
                            errors++;
                            $display("FAIL resp dut%0d: got %h at cycle %0d, required %h at cycle %0d",
                                     d, rdata[d], cyc, e, du);
                        end
                    end
                end else begin
                    if (due_q[d].size() > 0 && due_q[d][0] <= cyc) begin
                        compared++;
                        errors++;
                        e = exp_q[d].pop_front();
                        du = due_q[d].pop_front();
                        $display("FAIL resp_missing dut%0d: got no resp by cycle %0d, required %h at cycle %0d",
                                 d, cyc, e, du);
                    end
                    chk($sformatf("rdata_idle dut%0d", d), rdata[d], 32'h0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        req = '0;
        we  = '0;
        for (int d = 0; d < NDUT; d++) begin
            addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0; oor_m[d] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset_resp dut%0d", d), {31'h0, resp[d]}, 32'h0);
            chk($sformatf("reset_oor dut%0d", d), {16'h0, oor[d]}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // preload every word; dut1 holds 1..16 so words 0..3 are 1,2,3,4
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < DEPTH; i++)
                txn(d, 1'b1, BASE + 32'(4 * i), 4'hF, (d == 1) ? 32'(i + 1) : $urandom);
            idle(d, 1);
        end

        // T1/T2 on dut0
        txn(0, 1'b1, BASE + 4, 4'hF, 32'h12345678);
        txn(0, 1'b0, BASE + 4, 4'h0, 32'h0);
        idle(0, 2);
        txn(0, 1'b1, BASE + 4, 4'b0101, 32'hAABBCCDD);
        txn(0, 1'b0, BASE + 4, 4'h0, 32'h0);
        idle(0, 2);

        // T3 on dut1: four back-to-back reads
        for (int i = 0; i < 4; i++) txn(1, 1'b0, BASE + 32'(4 * i), 4'h0, 32'h0);
        idle(1, 5);

        // T4 on dut2: held req acks after two cycles, then drops
        txn(2, 1'b0, BASE + 8, 4'h0, 32'h0);
        req[2] = 1'b0;
        #1 chk("t4_ack_after_drop", {31'h0, ack[2]}, 32'h0);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = BASE + 12;
        #1 chk("t4_ack_cycle0", {31'h0, ack[2]}, 32'h0);
        @(negedge clk);
        req[2] = 1'b0;
        #1 chk("t4_ack_cycle1_dropped", {31'h0, ack[2]}, 32'h0);
        @(negedge clk);
        txn(2, 1'b0, BASE + 12, 4'h0, 32'h0);
        idle(2, 4);

        // T5: out-of-range write then read, RAM word 0 must be unchanged
        for (int d = 0; d < NDUT; d++) begin
            txn(d, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'h5555AAAA);
            txn(d, 1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0);
            txn(d, 1'b0, BASE, 4'h0, 32'h0);
            idle(d, 5);
            chk($sformatf("t5_oor dut%0d", d), {16'h0, oor[d]}, 32'(oor_m[d]));
        end

        // T6: reads in flight, reset with req held
        txn(1, 1'b0, BASE + 4, 4'h0, 32'h0);
        req[1] = 1'b0;
        txn(0, 1'b0, BASE + 4, 4'h0, 32'h0);
        rst = 1'b1;
        req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
        flush_all();
        #1;
        chk("t6_ack_in_reset dut0", {31'h0, ack[0]}, 32'h0);
        chk("t6_ack_in_reset dut1", {31'h0, ack[1]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int d = 0; d < NDUT; d++)
                chk($sformatf("t6_no_resp dut%0d c%0d", d, c), {31'h0, resp[d]}, 32'h0);
            @(negedge clk);
        end
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("t6_oor dut%0d", d), {16'h0, oor[d]}, 32'h0);
        txn(0, 1'b0, BASE + 4, 4'h0, 32'h0);
        idle(0, 1);
        txn(1, 1'b0, BASE + 4, 4'h0, 32'h0);
        idle(1, 5);

        // randomized traffic
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 200; n++) begin
                if ($urandom_range(0, 9) < 8) begin
                    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
                end else begin
                    a = $urandom;
                    if (in_rng(a)) a = a ^ 32'h8000_0000;
                end
                txn(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
                if ($urandom_range(0, 2) != 0) idle(d, $urandom_range(1, 2));
            end
            idle(d, 6);
            chk($sformatf("rand_oor dut%0d", d), {16'h0, oor[d]}, 32'(oor_m[d]));
        end

        repeat (10) @(negedge clk);
        #3;
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("drain_pending dut%0d", d), 32'(exp_q[d].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
